// File: rtl/alu_bit_serial_driver.sv
// alu_bit_serial_driver: runs WIDTH-bit ops LSB-first through an external 1-bit ALU slice.
// Define ALU_SEQ_OVERFLOW_EN to add the signed-overflow output ovf.
module alu_bit_serial_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [1:0]       op,
  input  logic             ena,
  input  logic             enb,
  input  logic             inva,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             done,
  output logic             s_a,
  output logic             s_b,
  output logic             s_ena,
  output logic             s_enb,
  output logic             s_inva,
  output logic             s_f0,
  output logic             s_f1,
  output logic             s_cin,
  input  logic             s_out,
  input  logic             s_cout
`ifdef ALU_SEQ_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [1:0]       op_q;
  logic             ena_q;
  logic             enb_q;
  logic             inva_q;
  logic             carry_reg;
  logic             cout_q;
  logic [CW-1:0]    cnt;

  logic accept;
  logic run;
  logic add_q;
  logic last;

  assign accept = (state == IDLE) && start;
  assign run    = (state == RUN);
  assign add_q  = (op_q == 2'b11);
  assign last   = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a      <= '0;
      sh_b      <= '0;
      res       <= '0;
      op_q      <= 2'b00;
      ena_q     <= 1'b0;
      enb_q     <= 1'b0;
      inva_q    <= 1'b0;
      carry_reg <= 1'b0;
      cout_q    <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      sh_a      <= a;
      sh_b      <= b;
      res       <= '0;
      op_q      <= op;
      ena_q     <= ena;
      enb_q     <= enb;
      inva_q    <= inva;
      carry_reg <= (op == 2'b11) & cin;
      cout_q    <= 1'b0;
      cnt       <= '0;
    end else if (run) begin
      res       <= {s_out, res[WIDTH-1:1]};
      sh_a      <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b      <= {1'b0, sh_b[WIDTH-1:1]};
      carry_reg <= add_q & s_cout;
      cnt       <= cnt + 1'b1;
      // final carry is latched here so it holds past DONE
      if (last) cout_q <= add_q & s_cout;
    end
  end

`ifdef ALU_SEQ_OVERFLOW_EN
  logic ovf_q;

  // carry_reg on the last RUN edge is the carry into the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (run && last) begin
      ovf_q <= add_q & (carry_reg ^ s_cout);
    end
  end

  assign ovf = ovf_q;
`endif

  assign ready  = (state == IDLE);
  assign done   = (state == DONE);
  assign result = res;
  assign cout   = cout_q;

  assign s_a    = run & sh_a[0];
  assign s_b    = run & sh_b[0];
  assign s_ena  = run & ena_q;
  assign s_enb  = run & enb_q;
  assign s_inva = run & inva_q;
  assign s_f0   = run & op_q[0];
  assign s_f1   = run & op_q[1];
  assign s_cin  = run & carry_reg;

endmodule

// File: tb/tb_alu_bit_serial_driver.sv
// Scoreboard bench for alu_bit_serial_driver with a behavioural 1-bit ALU slice.
module tb_alu_bit_serial_driver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         ready;
  logic [1:0]   op;
  logic         ena, enb, inva;
  logic [W-1:0] a, b;
  logic         cin;
  logic [W-1:0] result;
  logic         cout, done;
  logic         s_a, s_b, s_ena, s_enb, s_inva, s_f0, s_f1, s_cin;
  logic         s_out, s_cout;
  logic         ovf;

  alu_bit_serial_driver #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .op(op), .ena(ena), .enb(enb), .inva(inva),
    .a(a), .b(b), .cin(cin),
    .result(result), .cout(cout), .done(done),
    .s_a(s_a), .s_b(s_b), .s_ena(s_ena), .s_enb(s_enb),
    .s_inva(s_inva), .s_f0(s_f0), .s_f1(s_f1), .s_cin(s_cin),
    .s_out(s_out), .s_cout(s_cout)
`ifdef ALU_SEQ_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

`ifndef ALU_SEQ_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  // 1-bit ALU slice: A gated by ENA then optionally inverted, B gated by ENB
  logic ap, bp;
  always_comb begin
    ap     = (s_a & s_ena) ^ s_inva;
    bp     = s_b & s_enb;
    s_out  = 1'b0;
    s_cout = 1'b0;
    case ({s_f1, s_f0})
      2'b00: s_out = ap & bp;
      2'b01: s_out = ap | bp;
      2'b10: s_out = ~bp;
      default: begin
        s_out  = ap ^ bp ^ s_cin;
        s_cout = (ap & bp) | (s_cin & (ap ^ bp));
      end
    endcase
  end

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    int           mark;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   done_t[$];
  int   total = 0;
  int   bad   = 0;
  int   negs  = 0;
  int   dones = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    negs++;
    if (rst_n && done) begin
      dones++;
      done_t.push_back(negs);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pulse at neg %0d", negs);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, 32'(result), 32'(e.res));
        chk({e.name, "_cout"}, 32'(cout), 32'(e.c));
`ifdef ALU_SEQ_OVERFLOW_EN
        chk({e.name, "_ovf"}, 32'(ovf), 32'(e.v));
`endif
        chk({e.name, "_latency"}, 32'(negs - e.mark), 32'd9);
      end
    end
  end

  task automatic issue(input string nm, input logic [1:0] o,
                       input logic ea, input logic eb, input logic iv,
                       input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ci, input logic [W-1:0] er,
                       input logic ec, input logic ev, input logic hold);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL %s_ready_timeout: got ready=0 want 1", nm);
      return;
    end
    op = o; ena = ea; enb = eb; inva = iv;
    a = aa; b = bb; cin = ci; start = 1'b1;
    @(posedge clk);
    e.res = er; e.c = ec; e.v = ev; e.mark = negs; e.name = nm;
    sb.push_back(e);
    #1;
    if (!hold) start = 1'b0;
    @(negedge clk);
    chk({nm, "_ready_low"}, 32'(ready), 32'd0);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain_timeout: got %0d pending want 0", nm, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  int d0;
  logic [7:0] svec;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00;
    ena = 1'b0; enb = 1'b0; inva = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    svec = {s_a, s_b, s_ena, s_enb, s_inva, s_f0, s_f1, s_cin};
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_slice", 32'(svec), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("add5a3c", 2'b11, 1, 1, 0, 8'h5A, 8'h3C, 0, 8'h96, 0, 1, 0);
    issue("addff01", 2'b11, 1, 1, 0, 8'hFF, 8'h01, 0, 8'h00, 1, 0, 0);
    issue("sub",     2'b11, 1, 1, 1, 8'h03, 8'h0A, 1, 8'h07, 1, 0, 0);
    issue("addffff", 2'b11, 1, 1, 0, 8'hFF, 8'hFF, 1, 8'hFF, 1, 0, 0);
    issue("and",     2'b00, 1, 1, 0, 8'hF0, 8'h3C, 1, 8'h30, 0, 0, 0);
    issue("or",      2'b01, 1, 1, 0, 8'hF0, 8'h3C, 1, 8'hFC, 0, 0, 0);
    issue("notb",    2'b10, 1, 1, 0, 8'hF0, 8'h3C, 1, 8'hC3, 0, 0, 0);
    issue("inv_or",  2'b01, 0, 0, 1, 8'hF0, 8'h3C, 0, 8'hFF, 0, 0, 0);
    issue("inv_and", 2'b00, 0, 0, 1, 8'hF0, 8'h3C, 0, 8'h00, 0, 0, 0);
    drain("basic");

    d0 = dones;
    issue("ign", 2'b11, 1, 1, 0, 8'h10, 8'h22, 0, 8'h32, 0, 0, 0);
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; op = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("ign");
    repeat (4) @(negedge clk);
    chk("ign_one_done", 32'(dones - d0), 32'd1);

    issue("b2b_a", 2'b11, 1, 1, 0, 8'h7F, 8'h01, 0, 8'h80, 0, 1, 1);
    issue("b2b_b", 2'b01, 1, 1, 0, 8'h0F, 8'hF0, 0, 8'hFF, 0, 0, 0);
    drain("b2b");
    if (done_t.size() >= 2)
      chk("b2b_spacing", 32'(done_t[$] - done_t[$-1]), 32'd10);

    d0 = dones;
    issue("abort", 2'b11, 1, 1, 0, 8'h5A, 8'h3C, 0, 8'h96, 0, 1, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    svec = {s_a, s_b, s_ena, s_enb, s_inva, s_f0, s_f1, s_cin};
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_slice", 32'(svec), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(dones - d0), 32'd0);

    issue("add0101", 2'b11, 1, 1, 0, 8'h01, 8'h01, 0, 8'h02, 0, 0, 0);
    drain("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_bit_serial_driver.md
# alu_bit_serial_driver

Sequencer that drives the codebase's 1-bit ALU slice bit-serially to perform WIDTH-bit operations. Operands are accepted over a start/ready handshake and presented to the slice LSB-first, one bit per clock. The slice's Carry_out is registered and fed back as Carry_in on the next bit, and the per-bit results are assembled into a WIDTH-bit result. The block sits between the datapath control logic and one instance of the 1-bit ALU slice; the slice is combinational and external to this block.

## Interface
- WIDTH, 8, operand and result width in bits (≥2).

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when ready=1.
- ready  out  1  high in IDLE.
- op  in  2  {F1,F0}: 00 AND, 01 OR, 10 NOT B, 11 ADD.
- ena, enb, inva  in  1 each  slice enables and A inversion; latched at accept.
- a, b  in  WIDTH  operands; latched at accept.
- cin  in  1  initial carry, used only when op=11.
- result  out  WIDTH  assembled result.
- cout  out  1  final carry (0 unless op=11).
- done  out  1  one-cycle pulse; result and cout are valid.
- s_a, s_b, s_ena, s_enb, s_inva, s_f0, s_f1, s_cin  out  1 each  drive the slice.
- s_out, s_cout  in  1 each  slice Out and Carry_out.
- ovf  out  1  signed overflow (only with ALU_SEQ_OVERFLOW_EN).

## Operation
- Reset values: ready=1; done=0; result=0; cout=0; ovf=0; all s_* outputs 0; state IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start. At the accepting edge, latch a→sh_a, b→sh_b, and op/ena/enb/inva into control registers. Set carry_reg=cin if op=11, else 0. Set bit counter=0.
  - RUN: s_a=sh_a[0], s_b=sh_b[0], s_cin=carry_reg; s_ena/s_enb/s_inva/s_f1/s_f0 come from the latched controls. On each edge:
    - shift s_out into the result register at the MSB and shift it right;
    - shift sh_a and sh_b right;
    - carry_reg ← s_cout if op=11, else 0;
    - counter increments.
  - RUN→DONE after WIDTH bits, on the edge where the counter equals WIDTH-1.
  - DONE: done=1 for one cycle; cout=carry_reg. DONE→IDLE unconditionally.
- result and cout hold their values from DONE until the next accept. At the accepting edge, result clears to 0.
- s_* outputs are 0 in IDLE and DONE.
- start is ignored in RUN and DONE; no queuing.
- start held high in IDLE re-triggers a new operation immediately after DONE.
- Inputs are sampled only at the accepting edge; later changes have no effect.
- Subtraction b−a uses op=11, inva=1, cin=1.
- Asserting rst_n mid-operation aborts immediately: all outputs return to reset values and no done pulse is produced.

## Timing
- Accepting edge = edge 0. RUN occupies cycles 1..WIDTH; done is high during cycle WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles with start held high.
- Slice path is combinational: s_* registers → external slice → s_out/s_cout → capture registers, all within one clock period.
- ready falls in the cycle after the accepting edge and rises in the cycle after DONE.

## Configuration
- ALU_SEQ_OVERFLOW_EN defined:
  - ovf port exists.
  - An extra register captures the carry into the MSB (carry_reg before the last RUN edge).
  - In DONE, ovf = that carry XOR final carry when op=11; otherwise ovf=0.
  - ovf holds its value like result.
- Undefined: no ovf port and no extra register; all other behaviour is identical.

## Test plan
- WIDTH=8, op=11, ena=enb=1, inva=0, a=0x5A, b=0x3C, cin=0 → result=0x96, cout=0, ovf=1; done exactly 9 cycles after the accepting edge.
- op=11, a=0xFF, b=0x01, cin=0 → result=0x00, cout=1, ovf=0. Subtract: inva=1, cin=1, a=0x03, b=0x0A → result=0x07, cout=1.
- a=0xF0, b=0x3C: op=00 → 0x30; op=01 → 0xFC; op=10 → 0xC3. cout=0 in all three.
- ena=enb=0, inva=1, op=01 → result=0xFF. Same controls with op=00 → 0x00.
- start pulsed at RUN cycle 3 with different operands → ignored; first result is correct and only one done pulse occurs. start held high → back-to-back done pulses 10 cycles apart.
- rst_n asserted at RUN cycle 4 → result=0, ready=1, s_*=0 immediately, with no done. After release, a new ADD 0x01+0x01 → result=0x02.
